// File: rtl/core_ctrl_mc.sv
// Multi-cycle core sequencer: owns PC, instruction register, IF/IW/EX/MR/MW/WB/HALT FSM and commit trace.
// Optional feature macro CORE_CTRL_MISALIGN_EN: halt with err_o instead of loading a misaligned next PC.
module core_ctrl_mc #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            dec_ld_i,
  input  logic            dec_st_i,
  input  logic            dec_jal_i,
  input  logic            dec_jalr_i,
  input  logic            dec_br_i,
  input  logic            dec_ebreak_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] rs1_rdata_i,
  input  logic [XLEN-1:0] imm_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  input  logic            dmem_ready_i,
  input  logic            dmem_rvalid_i,
  output logic            rf_wen_o,
  output logic            commit_valid_o,
  output logic [XLEN-1:0] commit_pc_o,
  output logic [31:0]     commit_inst_o,
  output logic            halt_o,
  output logic            err_o
);

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_IW   = 3'd1,
    ST_EX   = 3'd2,
    ST_MR   = 3'd3,
    ST_MW   = 3'd4,
    ST_WB   = 3'd5,
    ST_HALT = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic            commit_valid_q, commit_valid_d;
  logic [XLEN-1:0] commit_pc_q, commit_pc_d;
  logic [31:0]     commit_inst_q, commit_inst_d;
  logic [XLEN-1:0] jalr_sum_s;
  logic [XLEN-1:0] target_s;
  logic            misalign_s;
  logic            inst_cap_s;
  logic            imem_req_s;
  logic            dmem_req_s;
  logic            dmem_we_s;
  logic            rf_wen_s;
  logic            halt_s;

  // Next-PC candidate for the instruction in writeback
  always_comb begin
    jalr_sum_s = rs1_rdata_i + imm_i;
    target_s   = pc_q + XLEN'(32'd4);
    if (dec_jalr_i) begin
      target_s = {jalr_sum_s[XLEN-1:1], 1'b0};
    end else if (dec_jal_i || (dec_br_i && br_taken_i)) begin
      target_s = pc_q + imm_i;
    end else begin
      target_s = pc_q + XLEN'(32'd4);
    end
  end

`ifdef CORE_CTRL_MISALIGN_EN
  logic err_q, err_d;

  assign misalign_s = (target_s[1:0] != 2'b00);
  assign err_d      = err_q | ((state_q == ST_WB) & misalign_s);

  // Sticky misaligned-target error flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign misalign_s = 1'b0;
  assign err_o      = 1'b0;
`endif

  // Sequencer next state and per-state control strobes
  always_comb begin
    state_d    = state_q;
    imem_req_s = 1'b0;
    dmem_req_s = 1'b0;
    dmem_we_s  = 1'b0;
    rf_wen_s   = 1'b0;
    halt_s     = 1'b0;
    case (state_q)
      ST_IF: begin
        imem_req_s = 1'b1;
        // rvalid without ready belongs to no request of ours
        if (imem_ready_i && imem_rvalid_i) begin
          state_d = ST_EX;
        end else if (imem_ready_i) begin
          state_d = ST_IW;
        end else begin
          state_d = ST_IF;
        end
      end
      ST_IW: begin
        if (imem_rvalid_i) begin
          state_d = ST_EX;
        end else begin
          state_d = ST_IW;
        end
      end
      ST_EX: begin
        if (dec_ld_i || dec_st_i) begin
          state_d = ST_MR;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MR: begin
        dmem_req_s = 1'b1;
        dmem_we_s  = dec_st_i;
        if (dec_st_i) begin
          if (dmem_ready_i) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_MR;
          end
        end else if (dmem_ready_i && dmem_rvalid_i) begin
          state_d = ST_WB;
        end else if (dmem_ready_i) begin
          state_d = ST_MW;
        end else begin
          state_d = ST_MR;
        end
      end
      ST_MW: begin
        if (dmem_rvalid_i) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_MW;
        end
      end
      ST_WB: begin
        rf_wen_s = ~dec_st_i & ~dec_br_i & ~dec_ebreak_i;
        if (dec_ebreak_i || misalign_s) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_IF;
        end
      end
      ST_HALT: begin
        halt_s  = 1'b1;
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IF;
      end
    endcase
  end

  assign inst_cap_s = ((state_q == ST_IF) && imem_ready_i && imem_rvalid_i) ||
                      ((state_q == ST_IW) && imem_rvalid_i);

  // PC, instruction register and commit trace updates
  always_comb begin
    pc_d           = pc_q;
    inst_d         = inst_q;
    commit_valid_d = 1'b0;
    commit_pc_d    = commit_pc_q;
    commit_inst_d  = commit_inst_q;
    if (inst_cap_s) begin
      inst_d = imem_rdata_i;
    end else begin
      inst_d = inst_q;
    end
    if (state_q == ST_WB) begin
      commit_valid_d = 1'b1;
      commit_pc_d    = pc_q;
      commit_inst_d  = inst_q;
      if (misalign_s) begin
        pc_d = pc_q;
      end else begin
        pc_d = target_s;
      end
    end else begin
      pc_d = pc_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IF;
      pc_q           <= RESET_PC;
      inst_q         <= 32'h0000_0000;
      commit_valid_q <= 1'b0;
      commit_pc_q    <= '0;
      commit_inst_q  <= 32'h0000_0000;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      inst_q         <= inst_d;
      commit_valid_q <= commit_valid_d;
      commit_pc_q    <= commit_pc_d;
      commit_inst_q  <= commit_inst_d;
    end
  end

  // Strobes are silenced while reset is held so no request leaks out mid-reset
  assign imem_req_o     = imem_req_s & ~rst_i;
  assign dmem_req_o     = dmem_req_s & ~rst_i;
  assign dmem_we_o      = dmem_we_s & ~rst_i;
  assign rf_wen_o       = rf_wen_s & ~rst_i;
  assign halt_o         = halt_s & ~rst_i;
  assign imem_addr_o    = pc_q;
  assign pc_o           = pc_q;
  assign inst_o         = inst_q;
  assign commit_valid_o = commit_valid_q;
  assign commit_pc_o    = commit_pc_q;
  assign commit_inst_o  = commit_inst_q;

endmodule

// File: tb/tb_core_ctrl_mc.sv
// Directed bench for core_ctrl_mc: instruction-level model (next PC, commit queue, halt/err) plus per-phase handshake checks.
`timescale 1ns/1ps
module tb_core_ctrl_mc;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_JAL = 3, K_JALR = 4, K_BR = 5, K_EB = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imem_req_o, imem_ready_i = 1'b0, imem_rvalid_i = 1'b0;
  logic [31:0] imem_addr_o, imem_rdata_i = 32'h0, inst_o, pc_o;
  logic dec_ld_i = 1'b0, dec_st_i = 1'b0, dec_jal_i = 1'b0, dec_jalr_i = 1'b0, dec_br_i = 1'b0, dec_ebreak_i = 1'b0;
  logic br_taken_i = 1'b0;
  logic [31:0] rs1_rdata_i = 32'h0, imm_i = 32'h0;
  logic dmem_req_o, dmem_we_o, dmem_ready_i = 1'b0, dmem_rvalid_i = 1'b0;
  logic rf_wen_o, commit_valid_o, halt_o, err_o;
  logic [31:0] commit_pc_o, commit_inst_o;

  always #5 clk = ~clk;

  core_ctrl_mc #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ready_i(imem_ready_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .inst_o(inst_o), .pc_o(pc_o),
    .dec_ld_i(dec_ld_i), .dec_st_i(dec_st_i), .dec_jal_i(dec_jal_i), .dec_jalr_i(dec_jalr_i),
    .dec_br_i(dec_br_i), .dec_ebreak_i(dec_ebreak_i), .br_taken_i(br_taken_i),
    .rs1_rdata_i(rs1_rdata_i), .imm_i(imm_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_ready_i(dmem_ready_i), .dmem_rvalid_i(dmem_rvalid_i),
    .rf_wen_o(rf_wen_o), .commit_valid_o(commit_valid_o), .commit_pc_o(commit_pc_o),
    .commit_inst_o(commit_inst_o), .halt_o(halt_o), .err_o(err_o)
  );

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } commit_t;

  // Architectural model state
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_inst = 32'h0;
  logic m_halt = 1'b0;
  logic m_err = 1'b0;
  commit_t exp_q[$];
  int commit_cyc[$];
  int cyc_cnt = 0;
  commit_t cmp_e;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] pc, input int k, input logic taken,
                                             input logic [31:0] rs1, input logic [31:0] imm);
    logic [31:0] t;
    case (k)
      K_JALR: begin
        t = rs1 + imm;
        t[0] = 1'b0;
      end
      K_JAL: t = pc + imm;
      K_BR: t = taken ? pc + imm : pc + 32'd4;
      default: t = pc + 32'd4;
    endcase
    return t;
  endfunction

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("pc", pc_o, m_pc);
      chk("imem_addr", imem_addr_o, m_pc);
      chk("halt", 32'(halt_o), 32'(m_halt));
      chk("err", 32'(err_o), 32'(m_err));
      if (exp_q.size() > 0) begin
        cmp_e = exp_q.pop_front();
        chk("commit_valid", 32'(commit_valid_o), 32'd1);
        chk("commit_pc", commit_pc_o, cmp_e.pc);
        chk("commit_inst", commit_inst_o, cmp_e.inst);
        commit_cyc.push_back(cyc_cnt);
      end else begin
        chk("no_commit", 32'(commit_valid_o), 32'd0);
      end
    end
  end

  task automatic do_reset(input int n);
    rst = 1'b1;
    imem_ready_i = 1'b0; imem_rvalid_i = 1'b0; dmem_ready_i = 1'b0; dmem_rvalid_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("rst_pc", pc_o, RST_PC);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_ireq", 32'(imem_req_o), 32'd0);
        chk("rst_dreq", 32'(dmem_req_o), 32'd0);
        chk("rst_wen", 32'(rf_wen_o), 32'd0);
        chk("rst_cv", 32'(commit_valid_o), 32'd0);
        chk("rst_halt", 32'(halt_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_cpc", commit_pc_o, 32'h0);
        chk("rst_cinst", commit_inst_o, 32'h0);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    m_pc = RST_PC; m_inst = 32'h0; m_halt = 1'b0; m_err = 1'b0;
    @(negedge clk);
    chk("post_rst_ireq", 32'(imem_req_o), 32'd1);
    @(posedge clk); #1;
  endtask

  // One instruction: fetch (fr cycles before ready, rvalid fw cycles after), EX, optional memory phase, WB
  task automatic exec(input logic [31:0] ins, input int k, input logic taken, input logic [31:0] rs1,
                      input logic [31:0] imm, input int fr, input int fw, input bit spur, input int mr, input int mw);
    logic ld, st, br, eb, mis;
    logic [31:0] nxt;
    ld = (k == K_LD); st = (k == K_ST); br = (k == K_BR); eb = (k == K_EB);
    dec_ld_i = ld; dec_st_i = st; dec_br_i = br; dec_ebreak_i = eb;
    dec_jal_i = (k == K_JAL); dec_jalr_i = (k == K_JALR);
    br_taken_i = taken; rs1_rdata_i = rs1; imm_i = imm;
    for (int i = 0; i <= fr; i++) begin
      imem_ready_i  = (i == fr);
      imem_rvalid_i = ((i == fr) && (fw == 0)) || (spur && (i < fr));
      imem_rdata_i  = (i == fr) ? ins : 32'hDEAD_BEEF;
      @(negedge clk);
      chk("if_req", 32'(imem_req_o), 32'd1);
      chk("if_dreq", 32'(dmem_req_o), 32'd0);
      @(posedge clk); #1;
    end
    imem_ready_i = 1'b0;
    for (int j = 1; j <= fw; j++) begin
      imem_rvalid_i = (j == fw);
      imem_rdata_i  = (j == fw) ? ins : 32'hDEAD_BEEF;
      @(negedge clk);
      chk("iw_req", 32'(imem_req_o), 32'd0);
      chk("iw_inst_held", inst_o, m_inst);
      @(posedge clk); #1;
    end
    imem_rvalid_i = 1'b0;
    @(negedge clk);
    chk("ex_inst", inst_o, ins);
    chk("ex_ireq", 32'(imem_req_o), 32'd0);
    chk("ex_dreq", 32'(dmem_req_o), 32'd0);
    chk("ex_wen", 32'(rf_wen_o), 32'd0);
    @(posedge clk); #1;
    if (ld || st) begin
      for (int i = 0; i <= mr; i++) begin
        dmem_ready_i  = (i == mr);
        dmem_rvalid_i = (i == mr) && ld && (mw == 0);
        @(negedge clk);
        chk("mr_req", 32'(dmem_req_o), 32'd1);
        chk("mr_we", 32'(dmem_we_o), 32'(st));
        chk("mr_wen", 32'(rf_wen_o), 32'd0);
        @(posedge clk); #1;
      end
      dmem_ready_i = 1'b0; dmem_rvalid_i = 1'b0;
      if (ld) begin
        for (int j = 1; j <= mw; j++) begin
          dmem_rvalid_i = (j == mw);
          @(negedge clk);
          chk("mw_req", 32'(dmem_req_o), 32'd0);
          chk("mw_wen", 32'(rf_wen_o), 32'd0);
          @(posedge clk); #1;
        end
      end
      dmem_rvalid_i = 1'b0;
    end
    @(negedge clk);
    chk("wb_wen", 32'(rf_wen_o), 32'(!st && !br && !eb));
    chk("wb_ireq", 32'(imem_req_o), 32'd0);
    chk("wb_dreq", 32'(dmem_req_o), 32'd0);
    nxt = model_next(m_pc, k, taken, rs1, imm);
`ifdef CORE_CTRL_MISALIGN_EN
    mis = (nxt[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    @(posedge clk); #1;
    exp_q.push_back({m_pc, ins});
    m_pc   = mis ? m_pc : nxt;
    m_inst = ins;
    m_halt = eb || mis;
    m_err  = m_err || mis;
  endtask

  task automatic idle_halt(input int n);
    imem_ready_i = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0013;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("halt_ireq", 32'(imem_req_o), 32'd0);
      chk("halt_dreq", 32'(dmem_req_o), 32'd0);
      chk("halt_wen", 32'(rf_wen_o), 32'd0);
      @(posedge clk); #1;
    end
    imem_ready_i = 1'b0; imem_rvalid_i = 1'b0;
  endtask

  task automatic reset_in_mr();
    dec_ld_i = 1'b1; dec_st_i = 1'b0; dec_jal_i = 1'b0; dec_jalr_i = 1'b0; dec_br_i = 1'b0; dec_ebreak_i = 1'b0;
    imem_ready_i = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_a283;
    @(negedge clk); chk("rmr_if_req", 32'(imem_req_o), 32'd1); @(posedge clk); #1;
    imem_ready_i = 1'b0; imem_rvalid_i = 1'b0;
    @(negedge clk); chk("rmr_ex_inst", inst_o, 32'h0000_a283); @(posedge clk); #1;
    @(negedge clk); chk("rmr_mr_req", 32'(dmem_req_o), 32'd1); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_pc = RST_PC; m_inst = 32'h0; m_halt = 1'b0; m_err = 1'b0;
    dmem_ready_i = 1'b1; dmem_rvalid_i = 1'b1; imem_rvalid_i = 1'b1;
    @(negedge clk);
    chk("rmr_dreq", 32'(dmem_req_o), 32'd0);
    chk("rmr_ireq", 32'(imem_req_o), 32'd1);
    chk("rmr_pc", pc_o, 32'h8000_0000);
    chk("rmr_inst", inst_o, 32'h0);
    @(posedge clk); #1;
    dmem_ready_i = 1'b0; dmem_rvalid_i = 1'b0; imem_rvalid_i = 1'b0;
  endtask

  initial begin
    do_reset(3);
    exec(32'h0010_0093, K_ALU, 1'b0, 32'h0, 32'h1, 0, 0, 1'b0, 0, 0);
    chk("addi_pc_lit", pc_o, 32'h8000_0004);
    chk("addi_cpc_lit", commit_pc_o, 32'h8000_0000);
    chk("addi_cv_lit", 32'(commit_valid_o), 32'd1);
    exec(32'h0020_0113, K_ALU, 1'b0, 32'h0, 32'h2, 0, 0, 1'b0, 0, 0);
    exec(32'h0030_0193, K_ALU, 1'b0, 32'h0, 32'h3, 1, 3, 1'b1, 0, 0);
    chk("fw_inst_lit", commit_inst_o, 32'h0030_0193);
    exec(32'h0000_a203, K_LD, 1'b0, 32'h0, 32'h0, 0, 0, 1'b0, 2, 1);
    exec(32'hfe00_0ce3, K_BR, 1'b1, 32'h0, 32'hFFFF_FFF8, 0, 0, 1'b0, 0, 0);
    chk("br_taken_lit", pc_o, 32'h8000_0008);
    exec(32'h0020_a023, K_ST, 1'b0, 32'h0, 32'h0, 0, 0, 1'b0, 1, 0);
    exec(32'h0020_8463, K_BR, 1'b0, 32'h0, 32'h8, 0, 0, 1'b0, 0, 0);
    chk("br_not_taken_lit", pc_o, 32'h8000_0010);
    exec(32'h0040_80e7, K_JALR, 1'b0, 32'h8000_0101, 32'h4, 0, 0, 1'b0, 0, 0);
    chk("jalr_lit", pc_o, 32'h8000_0104);
    exec(32'hf1df_f0ef, K_JAL, 1'b0, 32'h0, 32'hFFFF_FF1C, 0, 0, 1'b0, 0, 0);
    chk("jal_lit", pc_o, 32'h8000_0020);
    exec(32'h0010_0073, K_EB, 1'b0, 32'h0, 32'h0, 0, 0, 1'b0, 0, 0);
    chk("ebreak_cpc_lit", commit_pc_o, 32'h8000_0020);
    chk("ebreak_halt_lit", 32'(halt_o), 32'd1);
    idle_halt(4);
    chk("n_commits", 32'(commit_cyc.size()), 32'd10);
    chk("cpi_alu", 32'(commit_cyc[1] - commit_cyc[0]), 32'd3);
    chk("cpi_fetch_wait", 32'(commit_cyc[2] - commit_cyc[1]), 32'd7);
    chk("cpi_load", 32'(commit_cyc[3] - commit_cyc[2]), 32'd7);
    chk("cpi_store", 32'(commit_cyc[5] - commit_cyc[4]), 32'd5);
    do_reset(2);
    reset_in_mr();
    exec(32'h0080_8067, K_JALR, 1'b0, 32'hFFFF_FFFC, 32'h8, 0, 0, 1'b0, 0, 0);
    chk("jalr_wrap_lit", pc_o, 32'h0000_0004);
    exec(32'h0020_00ef, K_JAL, 1'b0, 32'h0, 32'h2, 0, 0, 1'b0, 0, 0);
`ifdef CORE_CTRL_MISALIGN_EN
    chk("mis_pc_lit", pc_o, 32'h0000_0004);
    chk("mis_err_lit", 32'(err_o), 32'd1);
    chk("mis_halt_lit", 32'(halt_o), 32'd1);
    idle_halt(2);
`else
    chk("mis_pc_lit", pc_o, 32'h0000_0006);
    chk("mis_err_lit", 32'(err_o), 32'd0);
    exec(32'h0010_0093, K_ALU, 1'b0, 32'h0, 32'h1, 0, 0, 1'b0, 0, 0);
    chk("after_mis_lit", pc_o, 32'h0000_000A);
`endif
    @(negedge clk); #1;
    chk("q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
